// File: rtl/apb_req_pkg.sv
// Shared types and helpers for the APB requester.
package apb_req_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

  // Cause of an rsp_err, for debug display only.
  typedef enum logic [1:0] {
    CAUSE_NONE,
    CAUSE_SLVERR,
    CAUSE_DECODE,
    CAUSE_TIMEOUT
  } rsp_cause_e;

  // Width of the slave-index field; at least one bit so vectors stay legal.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEFAULT_NUM_SLAVES = 4;
  localparam int unsigned SEL_W              = sel_width(DEFAULT_NUM_SLAVES);

endpackage

// File: rtl/apb_slave_decode.sv
// Slave-index decoder: index field of the command address -> one-hot select
// plus a decode error for indices with no peripheral behind them.
module apb_slave_decode
  import apb_req_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned SW         = sel_width(NUM_SLAVES)
) (
  input  logic [SW-1:0]         index,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  decode_err
);

  // One-hot select, suppressed entirely for out-of-range indices
  always_comb begin
    decode_err = (32'(index) >= NUM_SLAVES);
    sel        = '0;
    if (!decode_err) sel[index] = 1'b1;
  end

endmodule

// File: rtl/apb_requester_fsm.sv
// APB requester: valid/ready command -> IDLE/SETUP/ACCESS transfer.
// Optional macro APB_REQ_TIMEOUT_EN bounds the ACCESS phase to TIMEOUT_CYC
// cycles; without it ACCESS waits for pready indefinitely.
module apb_requester_fsm
  import apb_req_pkg::*;
#(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_SLAVES  = 4,
  parameter int unsigned SEL_LSB     = 12,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic [NUM_SLAVES-1:0] psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_W-1:0]     paddr,
  output logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int unsigned SW = sel_width(NUM_SLAVES);

  apb_state_e            state, state_next;
  logic [SW-1:0]         sel_index;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_err;
  logic                  accept, done, expired;

  logic                  cmd_ready_d, rsp_valid_d, rsp_err_d, penable_d, pwrite_d;
  logic [DATA_W-1:0]     rsp_rdata_d, pwdata_d;
  logic [NUM_SLAVES-1:0] psel_d;
  logic [ADDR_W-1:0]     paddr_d;

  // A single-slave bus has a zero-width index field: always slave 0
  if (NUM_SLAVES > 1) begin : g_idx
    assign sel_index = cmd_addr[SEL_LSB +: SW];
  end else begin : g_idx_one
    assign sel_index = '0;
  end

  apb_slave_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SW         (SW)
  ) u_decode (
    .index      (sel_index),
    .sel        (dec_sel),
    .decode_err (dec_err)
  );

  assign accept = cmd_valid && cmd_ready;
  assign done   = (state == ACCESS) && penable && pready;

`ifdef APB_REQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;

  // Counts stalled ACCESS cycles; zero on every entry to ACCESS
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                     to_cnt <= '0;
    else if (state != ACCESS)        to_cnt <= '0;
    else if (!pready)                to_cnt <= to_cnt + 1'b1;
  end

  // Expiry on the last allowed ACCESS cycle; a same-cycle pready wins
  assign expired = (state == ACCESS) && !pready && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  assign expired = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic; a decode error is answered without leaving IDLE
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept && !dec_err) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS:  if (done || expired) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    cmd_ready_d = cmd_ready;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
    rsp_err_d   = rsp_err;
    psel_d      = psel;
    penable_d   = penable;
    pwrite_d    = pwrite;
    paddr_d     = paddr;
    pwdata_d    = pwdata;
    unique case (state)
      IDLE: begin
        // cmd_ready re-arms one cycle after any response, since it was low then
        cmd_ready_d = !accept;
        if (accept) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          if (dec_err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            psel_d = dec_sel;
          end
        end
      end
      SETUP: penable_d = 1'b1;
      ACCESS: begin
        if (done) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          rsp_rdata_d = pwrite ? '0 : prdata;
        end else if (expired) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
    end else begin
      cmd_ready <= cmd_ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
      psel      <= psel_d;
      penable   <= penable_d;
      pwrite    <= pwrite_d;
      paddr     <= paddr_d;
      pwdata    <= pwdata_d;
    end
  end

endmodule

// File: tb/tb_apb_requester_fsm.sv
// Directed bench for apb_requester_fsm: a 4-slave instance for transfers and
// a 3-slave instance for the decode-error path.
module tb_apb_requester_fsm;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  // 4-slave instance
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [3:0]  psel;
  logic        penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;

  // 3-slave instance
  logic        cmd_valid3, cmd_ready3, cmd_write3;
  logic [15:0] cmd_addr3;
  logic [31:0] cmd_wdata3;
  logic        rsp_valid3, rsp_err3;
  logic [31:0] rsp_rdata3;
  logic [2:0]  psel3;
  logic        penable3, pwrite3;
  logic [15:0] paddr3;
  logic [31:0] pwdata3, prdata3;
  logic        pready3, pslverr3;

  int n_cmp = 0;
  int n_err = 0;

  apb_requester_fsm #(
    .ADDR_W(16), .DATA_W(32), .NUM_SLAVES(4), .SEL_LSB(12), .TIMEOUT_CYC(4)
  ) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  apb_requester_fsm #(
    .ADDR_W(16), .DATA_W(32), .NUM_SLAVES(3), .SEL_LSB(12), .TIMEOUT_CYC(4)
  ) dut3 (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_write(cmd_write3),
    .cmd_addr(cmd_addr3), .cmd_wdata(cmd_wdata3),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
    .psel(psel3), .penable(penable3), .pwrite(pwrite3), .paddr(paddr3),
    .pwdata(pwdata3), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command on the 4-slave instance and follow it to its response.
  // The slave answers on ACCESS cycle waits+1 (never, if waits is huge).
  task automatic do_cmd(input string tag, input logic w, input logic [15:0] a,
                        input logic [31:0] wd, input int waits,
                        input logic [31:0] rd, input logic se,
                        input logic [3:0] exp_psel, input int exp_lat,
                        input int exp_acc, input logic exp_err,
                        input logic [31:0] exp_rdata);
    int   n, acc;
    logic got, psel_ok, rdy_low;
    check_eq({tag, "_ready_at_issue"}, cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = wd;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    tick();
    cmd_valid = 1'b0;
    n = 0; acc = 0; got = 1'b0; psel_ok = 1'b1; rdy_low = 1'b1;
    while (n < 40 && !got) begin
      n++;
      if (rsp_valid) begin
        got = 1'b1;
      end else begin
        if (cmd_ready) rdy_low = 1'b0;
        if (psel !== exp_psel || paddr !== a || pwrite !== w) psel_ok = 1'b0;
        if (penable) begin
          acc++;
          pready  = (acc > waits);
          prdata  = (acc > waits) ? rd : 32'h0;
          pslverr = (acc > waits) ? se : 1'b0;
        end else begin
          pready = 1'b0;
        end
        tick();
      end
    end
    pready = 1'b0; pslverr = 1'b0;
    check_eq({tag, "_rsp_seen"}, got, 1'b1);
    check_eq({tag, "_latency"}, n, exp_lat);
    check_eq({tag, "_access_cycles"}, acc, exp_acc);
    check_eq({tag, "_psel_bus_stable"}, psel_ok, 1'b1);
    check_eq({tag, "_ready_low_during"}, rdy_low, 1'b1);
    check_eq({tag, "_rsp_err"}, rsp_err, exp_err);
    check_eq({tag, "_rsp_rdata"}, rsp_rdata, exp_rdata);
    check_eq({tag, "_psel_cleared"}, psel, 4'b0000);
    check_eq({tag, "_penable_cleared"}, penable, 1'b0);
    check_eq({tag, "_ready_in_rsp"}, cmd_ready, 1'b0);
  endtask

  initial begin
    resetn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    cmd_valid3 = 1'b0; cmd_write3 = 1'b0; cmd_addr3 = '0; cmd_wdata3 = '0;
    prdata3 = '0; pready3 = 1'b1; pslverr3 = 1'b0;
    #22 resetn = 1'b1;
    tick();

    check_eq("rst_cmd_ready", cmd_ready, 1'b1);
    check_eq("rst_psel", psel, 4'b0000);
    check_eq("rst_penable", penable, 1'b0);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_paddr", paddr, 16'h0000);
    check_eq("rst_pwdata", pwdata, 32'h0);

    // Write, no wait: slave 1
    do_cmd("wr0", 1'b1, 16'h1004, 32'hDEADBEEF, 0, 32'h0, 1'b0,
           4'b0010, 3, 1, 1'b0, 32'h0);
    check_eq("wr0_pwdata", pwdata, 32'hDEADBEEF);
    tick();
    check_eq("wr0_rsp_pulse_end", rsp_valid, 1'b0);
    check_eq("wr0_ready_rearm", cmd_ready, 1'b1);
    check_eq("wr0_err_hold", rsp_err, 1'b0);

    // Read with two wait states: slave 2
    do_cmd("rd2w", 1'b0, 16'h2010, 32'h0, 2, 32'h12345678, 1'b0,
           4'b0100, 5, 3, 1'b0, 32'h12345678);

    // Back-to-back: slave-error read, then a command held during rsp_valid
    tick();
    do_cmd("slverr", 1'b0, 16'h3000, 32'h0, 0, 32'hAAAA5555, 1'b1,
           4'b1000, 3, 1, 1'b1, 32'hAAAA5555);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0008; cmd_wdata = 32'h0BADF00D;
    tick();
    check_eq("b2b_ignored_psel", psel, 4'b0000);
    check_eq("b2b_ignored_rsp", rsp_valid, 1'b0);
    check_eq("b2b_err_hold", rsp_err, 1'b1);
    check_eq("b2b_rdata_hold", rsp_rdata, 32'hAAAA5555);
    do_cmd("b2b", 1'b1, 16'h0008, 32'h0BADF00D, 0, 32'h0, 1'b0,
           4'b0001, 3, 1, 1'b0, 32'h0);
    tick();

    // Reset during an ACCESS wait state
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 16'h1000; pready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    tick();
    check_eq("rstmid_in_access", penable, 1'b1);
    tick();
    #2 resetn = 1'b0;
    #1;
    check_eq("rstmid_psel", psel, 4'b0000);
    check_eq("rstmid_penable", penable, 1'b0);
    check_eq("rstmid_cmd_ready", cmd_ready, 1'b1);
    check_eq("rstmid_rsp_valid", rsp_valid, 1'b0);
    #3 resetn = 1'b1;
    tick();
    check_eq("rstmid_post_rsp", rsp_valid, 1'b0);
    check_eq("rstmid_post_psel", psel, 4'b0000);
    tick();
    check_eq("rstmid_post_rsp2", rsp_valid, 1'b0);

    // Decode error on the 3-slave instance: index 3 has no slave
    check_eq("dec_ready_before", cmd_ready3, 1'b1);
    cmd_valid3 = 1'b1; cmd_write3 = 1'b0; cmd_addr3 = 16'h3000;
    tick();
    cmd_valid3 = 1'b0;
    check_eq("dec_rsp_valid", rsp_valid3, 1'b1);
    check_eq("dec_rsp_err", rsp_err3, 1'b1);
    check_eq("dec_psel", psel3, 3'b000);
    check_eq("dec_cmd_ready", cmd_ready3, 1'b0);
    tick();
    check_eq("dec_rsp_pulse_end", rsp_valid3, 1'b0);
    check_eq("dec_ready_rearm", cmd_ready3, 1'b1);
    check_eq("dec_psel_after", psel3, 3'b000);
    check_eq("dec_penable_after", penable3, 1'b0);

`ifdef APB_REQ_TIMEOUT_EN
    // Slave never answers: abort after 4 ACCESS cycles
    do_cmd("tmo", 1'b0, 16'h1000, 32'h0, 1000, 32'h0, 1'b0,
           4'b0010, 6, 4, 1'b1, 32'h0);
    tick();
    check_eq("tmo_ready_rearm", cmd_ready, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
